mips_ctrl_fsm: RTL and testbench
================================

Name: mips_ctrl_fsm

Overview:
Parametrised successor to the single-cycle MIPS main controller. It decodes the opcode into datapath control and owns its own hazard state machine. The FSM covers branch resolve, a configurable flush after taken branches and jumps, and configurable load-use stalls. It sits between instruction fetch and the datapath, and drives pc_en, if_flush and the per-instruction control bits. It also keeps a saturating count of taken branches for lab statistics.

Parameters:
BR_STALL, 1, bubble cycles inserted after a taken BEQ/BNE or a J (0..7)
LD_STALL, 1, stall cycles inserted after LW (0..7)
CNT_W, 16, width of the taken-branch counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
instn  in  32  instruction word, valid every cycle; opcode = instn[31:26]
PCSrc  in  1  branch condition true, from the ALU compare, sampled in BR_RES
RegDst  out  1  write-register select (1 = rd)
ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
ALUSrc  out  1  ALU B operand = sign-extended immediate
branch  out  1  branch instruction in decode
jump  out  1  J in decode
MemRead  out  1  data memory read
MemWrite  out  1  data memory write
RegWrite  out  1  register-file write
MemtoReg  out  1  write-back from memory
pc_en  out  1  PC update enable
if_flush  out  1  squash the fetched instruction
busy  out  1  FSM not in NORMAL
state  out  2  current FSM state (debug)
taken_cnt  out  CNT_W  taken branches/jumps since reset, saturating

Behaviour:
- Reset (rst=1 at a clk edge) gives state=NORMAL, stall counter=0, taken_cnt=0. While rst is high, all control outputs, pc_en and if_flush are 0.
- Reset mid-stall aborts the stall. The FSM is in NORMAL on the next cycle.
- State encoding: NORMAL=0, BR_RES=1, FLUSH=2, LD_WAIT=3.
- Control outputs are combinational from opcode and state. In any state other than NORMAL they are forced to NOP (all 0).
- Decode table in NORMAL. Fields are RegDst, ALUOp, ALUSrc, branch, jump, MemRead, MemWrite, RegWrite, MemtoReg:
  - Rtype: 1, 10, 0, 0, 0, 0, 0, 1, 0
  - ADDI and SET: 0, 00, 1, 0, 0, 0, 0, 1, 0
  - LW: 0, 00, 1, 0, 0, 1, 0, 1, 1
  - SW: 0, 00, 1, 0, 0, 0, 1, 0, 0
  - BEQ and BNE: 0, 01, 0, 1, 0, 0, 0, 0, 0
  - J: all 0 except jump=1
  - Unknown opcode: all 0. The FSM stays in NORMAL.
- Register is_bne at the BEQ/BNE edge.
- Transitions from NORMAL:
  - BEQ or BNE: pc_en=0 this cycle; next state BR_RES.
  - J: pc_en=1. Taken_cnt increments. If BR_STALL>0, go to FLUSH with cnt=BR_STALL-1; otherwise stay in NORMAL.
  - LW: pc_en=1. If LD_STALL>0, go to LD_WAIT with cnt=LD_STALL-1.
  - Any other opcode: pc_en=1, stay in NORMAL.
- BR_RES: pc_en=1, if_flush=0. taken = PCSrc XOR is_bne.
  - If taken: taken_cnt increments. Go to FLUSH with cnt=BR_STALL-1 when BR_STALL>0; otherwise go to NORMAL.
  - If not taken: go to NORMAL.
- FLUSH: if_flush=1, pc_en=1. If cnt==0, go to NORMAL; otherwise cnt decrements.
- LD_WAIT: pc_en=0, if_flush=0. If cnt==0, go to NORMAL; otherwise cnt decrements.
- busy = (state != NORMAL).
- PCSrc is ignored outside BR_RES.
- taken_cnt saturates at all-ones and does not wrap.
- Latency summary:
  - Not-taken branch: 2 cycles.
  - Taken branch: 2 + BR_STALL cycles.
  - J: 1 + BR_STALL cycles.
  - LW: 1 + LD_STALL cycles.
- Stall counter width is 3 bits. Parameter values above 7 are illegal; add an elaboration check.

Decomposition:
- Package mips_ctrl_pkg:
  - Opcode constants: Rtype 000000, J 000010, BEQ 000100, BNE 000101, ADDI 001000, SET 001111, LW 100011, SW 101011.
  - ALUOp constants.
  - State encoding.
  - A packed control-bundle typedef.
- Sub-module mips_main_decoder: purely combinational opcode-to-bundle decode, instantiated once. The FSM, counters and NOP gating stay at the top level.

Test Plan:
- Reset: assert rst for 2 cycles with instn=LW → all control 0, pc_en=0, state=0, taken_cnt=0. Release → LW decode visible the same cycle, MemRead=1.
- BEQ taken, BR_STALL=2: opcode 000100, then PCSrc=1 in BR_RES.
  - pc_en sequence 0,1,1,1; if_flush sequence 0,0,1,1; state 0,1,2,2,0.
  - taken_cnt=1 afterwards.
- BNE with PCSrc=1 (not taken) → state 0,1,0, if_flush never 1, taken_cnt unchanged. Repeat with PCSrc=0 → FLUSH entered, taken_cnt increments.
- LW, LD_STALL=1 → pc_en 1,0 then 1; controls NOP during LD_WAIT. Rebuild with LD_STALL=0 → no LD_WAIT entry.
- Reset mid-FLUSH: rst in the first FLUSH cycle → state=NORMAL next cycle, taken_cnt=0, if_flush=0.
- Saturation: CNT_W=2, issue 5 J instructions → taken_cnt holds at 3. Unknown opcode 111111 → all control 0, busy=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, ALUOp, FSM-state and control-bundle definitions for the MIPS main controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SET   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_BR_RES  = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_LD_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic is_cond_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/mips_main_decoder.sv
// Purely combinational opcode-to-control decode; unknown opcodes decode to a NOP bundle.
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_NOP;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
        ctrl_o.reg_write = 1'b1;
      end
      OP_ADDI, OP_SET: begin
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.alu_op = ALUOP_SUB;
        ctrl_o.branch = 1'b1;
      end
      OP_J: ctrl_o.jump = 1'b1;
      default: ctrl_o = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// MIPS main controller with branch-resolve, post-taken flush and load-use stall FSM,
// plus a saturating taken-branch/jump counter.
module mips_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int BR_STALL = 1,
  parameter int LD_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instn,
  input  logic             PCSrc,
  output logic             RegDst,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             branch,
  output logic             jump,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             pc_en,
  output logic             if_flush,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] taken_cnt
);

  if (BR_STALL < 0 || BR_STALL > 7) begin : g_bad_br_stall
    $error("mips_ctrl_fsm: BR_STALL must be in 0..7");
  end
  if (LD_STALL < 0 || LD_STALL > 7) begin : g_bad_ld_stall
    $error("mips_ctrl_fsm: LD_STALL must be in 0..7");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mips_ctrl_fsm: CNT_W must be at least 1");
  end

  localparam bit             BR_EN       = (BR_STALL > 0);
  localparam bit             LD_EN       = (LD_STALL > 0);
  localparam logic [2:0]     BR_CNT_INIT = BR_EN ? 3'(BR_STALL - 1) : 3'd0;
  localparam logic [2:0]     LD_CNT_INIT = LD_EN ? 3'(LD_STALL - 1) : 3'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              is_bne_q;
  logic [CNT_W-1:0]  taken_cnt_q;

  logic [5:0] opcode;
  ctrl_t      dec_ctrl;
  ctrl_t      ctrl;
  logic       pc_en_d;
  logic       if_flush_d;
  logic       taken_d;
  logic       unused_operand_bits;

  assign opcode = instn[31:26];
  // Operand fields are consumed by the datapath, not by this controller.
  assign unused_operand_bits = ^instn[25:0];

  mips_main_decoder u_decoder (
    .opcode_i (opcode),
    .ctrl_o   (dec_ctrl)
  );

  always_comb begin
    pc_en_d    = 1'b0;
    if_flush_d = 1'b0;
    taken_d    = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        pc_en_d = !is_cond_branch(opcode);
        taken_d = (opcode == OP_J);
      end
      ST_BR_RES: begin
        pc_en_d = 1'b1;
        taken_d = PCSrc ^ is_bne_q;
      end
      ST_FLUSH: begin
        pc_en_d    = 1'b1;
        if_flush_d = 1'b1;
      end
      default: pc_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      cnt_q       <= 3'd0;
      is_bne_q    <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      if (taken_d && taken_cnt_q != CNT_MAX) begin
        taken_cnt_q <= taken_cnt_q + 1'b1;
      end
      case (state_q)
        ST_NORMAL: begin
          if (is_cond_branch(opcode)) begin
            is_bne_q <= (opcode == OP_BNE);
            state_q  <= ST_BR_RES;
          end else if (opcode == OP_J && BR_EN) begin
            state_q <= ST_FLUSH;
            cnt_q   <= BR_CNT_INIT;
          end else if (opcode == OP_LW && LD_EN) begin
            state_q <= ST_LD_WAIT;
            cnt_q   <= LD_CNT_INIT;
          end
        end
        ST_BR_RES: begin
          if (taken_d && BR_EN) begin
            state_q <= ST_FLUSH;
            cnt_q   <= BR_CNT_INIT;
          end else begin
            state_q <= ST_NORMAL;
          end
        end
        ST_FLUSH, ST_LD_WAIT: begin
          if (cnt_q == 3'd0) state_q <= ST_NORMAL;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        default: state_q <= ST_NORMAL;
      endcase
    end
  end

  // Decoded controls only leave the block in NORMAL; stalls and reset emit a NOP.
  assign ctrl = (!rst && state_q == ST_NORMAL) ? dec_ctrl : CTRL_NOP;

  assign RegDst    = ctrl.reg_dst;
  assign ALUOp     = ctrl.alu_op;
  assign ALUSrc    = ctrl.alu_src;
  assign branch    = ctrl.branch;
  assign jump      = ctrl.jump;
  assign MemRead   = ctrl.mem_read;
  assign MemWrite  = ctrl.mem_write;
  assign RegWrite  = ctrl.reg_write;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign pc_en     = pc_en_d && !rst;
  assign if_flush  = if_flush_d && !rst;
  assign busy      = (state_q != ST_NORMAL);
  assign state     = state_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Self-checking bench: three controller builds share one stimulus stream and are
// compared each cycle against a phase-queue reference model.
module tb_mips_ctrl_fsm;

  localparam logic [5:0] T_R = 6'b000000, T_J = 6'b000010, T_BEQ = 6'b000100, T_BNE = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000, T_SET = 6'b001111, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instn;
  logic        PCSrc;

  logic [2:0][9:0] o_ctrl;
  logic [2:0]      o_pc, o_fl, o_busy;
  logic [2:0][1:0] o_st;
  logic [15:0]     tc_a, tc_b;
  logic [1:0]      tc_c;

  int n_assert = 0;
  int n_fail   = 0;

  int brs [3] = '{2, 0, 1};
  int lds [3] = '{1, 0, 3};
  int cws [3] = '{16, 16, 2};
  int m_res [3];
  int m_bne [3];
  int m_fl  [3];
  int m_ld  [3];
  int m_cnt [3];

  always #5 clk = ~clk;

  mips_ctrl_fsm #(.BR_STALL(2), .LD_STALL(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .instn(instn), .PCSrc(PCSrc),
    .RegDst(o_ctrl[0][9]), .ALUOp(o_ctrl[0][8:7]), .ALUSrc(o_ctrl[0][6]), .branch(o_ctrl[0][5]),
    .jump(o_ctrl[0][4]), .MemRead(o_ctrl[0][3]), .MemWrite(o_ctrl[0][2]), .RegWrite(o_ctrl[0][1]),
    .MemtoReg(o_ctrl[0][0]), .pc_en(o_pc[0]), .if_flush(o_fl[0]), .busy(o_busy[0]),
    .state(o_st[0]), .taken_cnt(tc_a));

  mips_ctrl_fsm #(.BR_STALL(0), .LD_STALL(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .instn(instn), .PCSrc(PCSrc),
    .RegDst(o_ctrl[1][9]), .ALUOp(o_ctrl[1][8:7]), .ALUSrc(o_ctrl[1][6]), .branch(o_ctrl[1][5]),
    .jump(o_ctrl[1][4]), .MemRead(o_ctrl[1][3]), .MemWrite(o_ctrl[1][2]), .RegWrite(o_ctrl[1][1]),
    .MemtoReg(o_ctrl[1][0]), .pc_en(o_pc[1]), .if_flush(o_fl[1]), .busy(o_busy[1]),
    .state(o_st[1]), .taken_cnt(tc_b));

  mips_ctrl_fsm #(.BR_STALL(1), .LD_STALL(3), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .instn(instn), .PCSrc(PCSrc),
    .RegDst(o_ctrl[2][9]), .ALUOp(o_ctrl[2][8:7]), .ALUSrc(o_ctrl[2][6]), .branch(o_ctrl[2][5]),
    .jump(o_ctrl[2][4]), .MemRead(o_ctrl[2][3]), .MemWrite(o_ctrl[2][2]), .RegWrite(o_ctrl[2][1]),
    .MemtoReg(o_ctrl[2][0]), .pc_en(o_pc[2]), .if_flush(o_fl[2]), .busy(o_busy[2]),
    .state(o_st[2]), .taken_cnt(tc_c));

  // {RegDst, ALUOp[1:0], ALUSrc, branch, jump, MemRead, MemWrite, RegWrite, MemtoReg}
  function automatic logic [9:0] exp_dec(input logic [5:0] op);
    case (op)
      T_R:           return 10'b1_10_0_0_0_0_0_1_0;
      T_ADDI, T_SET: return 10'b0_00_1_0_0_0_0_1_0;
      T_LW:          return 10'b0_00_1_0_0_1_0_1_1;
      T_SW:          return 10'b0_00_1_0_0_0_1_0_0;
      T_BEQ, T_BNE:  return 10'b0_01_0_1_0_0_0_0_0;
      T_J:           return 10'b0_00_0_0_1_0_0_0_0;
      default:       return 10'b0;
    endcase
  endfunction

  // Pending phases: resolve cycle first, then flush cycles, then load-wait cycles.
  function automatic int m_state(input int i);
    if (m_res[i] != 0) return 1;
    if (m_fl[i] > 0)   return 2;
    if (m_ld[i] > 0)   return 3;
    return 0;
  endfunction

  function automatic logic [31:0] obs_tc(input int i);
    if (i == 0) return {16'b0, tc_a};
    if (i == 1) return {16'b0, tc_b};
    return {30'b0, tc_c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int         s;
      logic [5:0] op;
      logic [9:0] e_ctrl;
      logic       e_pc;
      logic       e_fl;
      s  = m_state(i);
      op = instn[31:26];
      e_ctrl = (!rst && s == 0) ? exp_dec(op) : 10'b0;
      if (rst)         e_pc = 1'b0;
      else if (s == 0) e_pc = !(op == T_BEQ || op == T_BNE);
      else             e_pc = (s == 1 || s == 2);
      e_fl = !rst && (s == 2);
      chk($sformatf("dut%0d_ctrl", i), {22'b0, o_ctrl[i]}, {22'b0, e_ctrl});
      chk($sformatf("dut%0d_pc_en", i), {31'b0, o_pc[i]}, {31'b0, e_pc});
      chk($sformatf("dut%0d_if_flush", i), {31'b0, o_fl[i]}, {31'b0, e_fl});
      chk($sformatf("dut%0d_busy", i), {31'b0, o_busy[i]}, (s != 0) ? 32'd1 : 32'd0);
      chk($sformatf("dut%0d_state", i), {30'b0, o_st[i]}, 32'(s));
      chk($sformatf("dut%0d_taken_cnt", i), obs_tc(i), 32'(m_cnt[i]));
    end
  endtask

  task automatic model_update();
    logic [5:0] op;
    op = instn[31:26];
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_res[i] = 0; m_bne[i] = 0; m_fl[i] = 0; m_ld[i] = 0; m_cnt[i] = 0;
      end else if (m_res[i] != 0) begin
        m_res[i] = 0;
        if ((PCSrc ? 1 : 0) != m_bne[i]) begin
          if (m_cnt[i] < (1 << cws[i]) - 1) m_cnt[i]++;
          m_fl[i] = brs[i];
        end
      end else if (m_fl[i] > 0) begin
        m_fl[i]--;
      end else if (m_ld[i] > 0) begin
        m_ld[i]--;
      end else if (op == T_BEQ || op == T_BNE) begin
        m_res[i] = 1;
        m_bne[i] = (op == T_BNE) ? 1 : 0;
      end else if (op == T_J) begin
        if (m_cnt[i] < (1 << cws[i]) - 1) m_cnt[i]++;
        m_fl[i] = brs[i];
      end else if (op == T_LW) begin
        m_ld[i] = lds[i];
      end
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic pc, input logic r);
    instn = {op, 26'($urandom)};
    PCSrc = pc;
    rst   = r;
    #3;
    check_all();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(T_R, 1'b0, 1'b0);
      adv();
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{T_R, T_J, T_BEQ, T_BNE, T_ADDI, T_SET, T_LW, T_SW};
    rst = 1'b1; PCSrc = 1'b0; instn = {T_LW, 26'b0};
    for (int i = 0; i < 3; i++) begin
      m_res[i] = 0; m_bne[i] = 0; m_fl[i] = 0; m_ld[i] = 0; m_cnt[i] = 0;
    end
    @(posedge clk);
    #1;

    // Reset held two cycles with LW on the bus, then released.
    drive(T_LW, 1'b0, 1'b1); adv();
    drive(T_LW, 1'b0, 1'b1);
    chk("rst_memread", {31'b0, o_ctrl[0][3]}, 32'd0);
    adv();
    drive(T_LW, 1'b0, 1'b0);
    chk("rel_memread", {31'b0, o_ctrl[0][3]}, 32'd1);
    adv();
    drive(T_R, 1'b0, 1'b0);
    chk("lw_wait_pc", {31'b0, o_pc[0]}, 32'd0);
    chk("lw_wait_st_b", {30'b0, o_st[1]}, 32'd0);
    adv();
    idle(4);

    // BEQ taken on the BR_STALL=2 build.
    drive(T_BEQ, 1'b0, 1'b0); chk("beq_pc0", {31'b0, o_pc[0]}, 32'd0); adv();
    drive(T_R, 1'b1, 1'b0);   chk("beq_st1", {30'b0, o_st[0]}, 32'd1); adv();
    drive(T_R, 1'b0, 1'b0);   chk("beq_fl2", {31'b0, o_fl[0]}, 32'd1); adv();
    drive(T_R, 1'b0, 1'b0);   chk("beq_st3", {30'b0, o_st[0]}, 32'd2); adv();
    drive(T_R, 1'b0, 1'b0);   chk("beq_cnt", {16'b0, tc_a}, 32'd1); adv();

    // BNE with PCSrc=1 is not taken; with PCSrc=0 it is.
    drive(T_BNE, 1'b0, 1'b0); adv();
    drive(T_R, 1'b1, 1'b0);   adv();
    drive(T_R, 1'b0, 1'b0);   chk("bne_nt_st", {30'b0, o_st[0]}, 32'd0); adv();
    drive(T_BNE, 1'b0, 1'b0); adv();
    drive(T_R, 1'b0, 1'b0);   adv();
    drive(T_R, 1'b0, 1'b0);   chk("bne_t_st", {30'b0, o_st[0]}, 32'd2);
    chk("bne_t_cnt", {16'b0, tc_a}, 32'd2); adv();
    idle(3);

    // Reset during the first flush cycle after a J.
    drive(T_J, 1'b0, 1'b0); adv();
    drive(T_R, 1'b0, 1'b1); chk("rstfl_fl", {31'b0, o_fl[0]}, 32'd0); adv();
    drive(T_R, 1'b0, 1'b0); chk("rstfl_st", {30'b0, o_st[0]}, 32'd0);
    chk("rstfl_cnt", {16'b0, tc_a}, 32'd0); adv();

    // Five jumps saturate the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      drive(T_J, 1'b0, 1'b0); adv();
      idle(2);
    end
    drive(T_BAD, 1'b0, 1'b0);
    chk("sat_cnt", {30'b0, tc_c}, 32'd3);
    chk("bad_ctrl", {22'b0, o_ctrl[0]}, 32'd0);
    chk("bad_busy", {31'b0, o_busy[0]}, 32'd0);
    adv();

    // Randomised traffic including unknown opcodes and sporadic resets.
    for (int k = 0; k < 300; k++) begin
      logic [5:0] op;
      int         sel;
      sel = $urandom_range(0, 9);
      op  = (sel < 8) ? ops[sel] : 6'($urandom);
      drive(op, 1'($urandom), ($urandom_range(0, 39) == 0));
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
